ssb_re_demapper: RTL and testbench
==================================

Name: ssb_re_demapper

Overview:
- Consumes the per-SSB resource-element stream produced by the SSB extraction stage: 4 OFDM symbols × 240 subcarriers.
- Classifies every RE by position into PBCH data, PBCH DMRS or SSS, and emits each class on its own AXI-stream-like output; PSS REs and unused REs are dropped.
- Feeds the PBCH channel estimator (DMRS), the PBCH equalizer/decoder (data) and the SSS detector (SSS).

Parameters:
IN_DW, 16, RE data width (packed I/Q), applies to input and all outputs
NID_WIDTH, 10, width of the cell ID input (N_id 0..1007)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
N_id_i  in  NID_WIDTH  physical cell ID; bits [1:0] give DMRS offset v
s_axis_in_tdata  in  IN_DW  SSB RE
s_axis_in_tlast  in  1  last RE of one SSB symbol (RE index 239)
s_axis_in_tvalid  in  1  RE valid
m_axis_pbch_tdata  out  IN_DW  PBCH data RE
m_axis_pbch_tlast  out  1  last of 432 PBCH data REs in the SSB
m_axis_pbch_tvalid  out  1  PBCH data valid
m_axis_dmrs_tdata  out  IN_DW  PBCH DMRS RE
m_axis_dmrs_tlast  out  1  last of 144 DMRS REs in the SSB
m_axis_dmrs_tvalid  out  1  DMRS valid
m_axis_sss_tdata  out  IN_DW  SSS RE
m_axis_sss_tlast  out  1  last of 127 SSS REs
m_axis_sss_tvalid  out  1  SSS valid
ssb_done_o  out  1  one-cycle pulse: SSB fully demapped
err_o  out  1  one-cycle pulse: tlast misalignment detected

Behaviour:
- Reset (async, reset_i=1): all outputs 0, sc_cnt=0, sym_cnt=0, v_reg=0, class counters=0. Release is synchronous to clk_i.
- No backpressure: there are no tready ports, and the input is accepted on every valid cycle.
- Counters:
  - sc_cnt runs 0..239 and sym_cnt runs 0..3; both advance only when s_axis_in_tvalid=1.
  - sc_cnt wraps 239→0 and increments sym_cnt; sym_cnt wraps 3→0.
- v_reg loads N_id_i[1:0] on the accepted RE with sym_cnt=0 and sc_cnt=0. It is held for the whole SSB, so mid-SSB N_id_i changes are ignored.
- Classification of the accepted RE (sc = sc_cnt; the DMRS test uses v_reg, or N_id_i[1:0] on the first RE):
  - sym 0: all REs dropped (PSS/unused).
  - sym 1 and sym 3: sc mod 4 == v → DMRS, else PBCH.
  - sym 2, sc 0..47 or 192..239: sc mod 4 == v → DMRS, else PBCH.
  - sym 2, sc 56..182: SSS. All other sym 2 REs are dropped.
- Outputs are registered with 1-cycle latency: the RE accepted at cycle n appears at cycle n+1.
  - tvalid of the selected class is 1 for exactly one cycle; the other classes' tvalid is 0.
  - tdata updates only for the selected class; the other outputs hold their last value.
- Per-SSB class totals: PBCH 432 (180+72+180), DMRS 144 (60+24+60), SSS 127.
- Class tlast:
  - PBCH: count==431.
  - DMRS: count==143, asserted on sym 3, sc 236+v.
  - SSS: sc 182 of sym 2.
  - Class counters reset to 0 at SSB end and on error.
- ssb_done_o pulses 1 cycle after the RE with sym_cnt=3, sc_cnt=239. It coincides with the final PBCH or DMRS output beat.
- tlast checking:
  - tlast=1 with sc_cnt≠239: err_o pulse at +1 cycle, that RE is still classified/output, then sc_cnt, sym_cnt and class counters go to 0 (resync to a new SSB).
  - sc_cnt=239 with tlast=0: same err_o and resync.
  - No ssb_done_o is issued for an aborted SSB.
- tvalid gaps: counters and outputs freeze; output tvalid drops to 0 during the gap.
- Reset mid-SSB: everything returns to reset values immediately; the next valid RE is treated as sym 0, sc 0.

Test Plan:
- N_id=0 (v=0), one contiguous SSB with tdata=sym*256+sc → PBCH count 432 with tlast on the last beat; DMRS count 144, first DMRS data 0x100 and last 0x3EC; SSS count 127 spanning 0x238..0x2B6; one ssb_done_o.
- N_id=1003 (v=3), same stimulus → first DMRS 0x103, last DMRS 0x3EF; PBCH/DMRS counts still 432/144; no DMRS emitted from sc 48..191 of sym 2.
- N_id_i changed from 0 to 2 at sym 1 sc 10 → DMRS positions stay at sc mod 4==0 for the whole SSB; the next SSB uses v=2.
- Random tvalid gaps (30% idle) over 3 back-to-back SSBs → each output stream is identical to the gap-free run, with 3 ssb_done_o pulses.
- tlast injected at sym 1 sc 100 → err_o pulse one cycle later, no ssb_done_o; the following clean SSB demaps correctly with all counts exact.
- reset_i asserted asynchronously at sym 2 sc 120 → all outputs 0 within the same cycle; after release a clean SSB yields the correct counts.

Source files
------------

// File: rtl/ssb_re_demapper.sv
// rtl/ssb_re_demapper.sv - SSB resource-element demapper into PBCH data, PBCH DMRS and SSS streams
module ssb_re_demapper #(
    parameter int IN_DW     = 16,
    parameter int NID_WIDTH = 10
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NID_WIDTH-1:0] N_id_i,
    input  logic [IN_DW-1:0]     s_axis_in_tdata,
    input  logic                 s_axis_in_tlast,
    input  logic                 s_axis_in_tvalid,
    output logic [IN_DW-1:0]     m_axis_pbch_tdata,
    output logic                 m_axis_pbch_tlast,
    output logic                 m_axis_pbch_tvalid,
    output logic [IN_DW-1:0]     m_axis_dmrs_tdata,
    output logic                 m_axis_dmrs_tlast,
    output logic                 m_axis_dmrs_tvalid,
    output logic [IN_DW-1:0]     m_axis_sss_tdata,
    output logic                 m_axis_sss_tlast,
    output logic                 m_axis_sss_tvalid,
    output logic                 ssb_done_o,
    output logic                 err_o
);

    localparam logic [7:0] SC_LAST     = 8'd239;
    localparam logic [8:0] PBCH_LAST   = 9'd431;
    localparam logic [7:0] DMRS_LAST   = 8'd143;

    logic [7:0] sc_cnt;
    logic [1:0] sym_cnt;
    logic [1:0] v_reg;
    logic [8:0] pbch_cnt;
    logic [7:0] dmrs_cnt;

    logic [1:0] v_eff;
    logic       first_re;
    logic       at_last;
    logic       pbch_band;
    logic       sss_band;
    logic       sel_pbch;
    logic       sel_dmrs;
    logic       sel_sss;
    logic       tlast_err;
    logic       ssb_end;
    logic       nid_unused;

    // Only the DMRS offset bits of the cell ID matter here.
    assign nid_unused = ^N_id_i[NID_WIDTH-1:2];

    always_comb begin
        first_re  = (sym_cnt == 2'd0) && (sc_cnt == 8'd0);
        // The first RE of an SSB must already see the new offset, before v_reg has loaded.
        v_eff     = first_re ? N_id_i[1:0] : v_reg;
        at_last   = (sc_cnt == SC_LAST);
        pbch_band = (sym_cnt == 2'd1) || (sym_cnt == 2'd3) ||
                    ((sym_cnt == 2'd2) && ((sc_cnt <= 8'd47) || (sc_cnt >= 8'd192)));
        sss_band  = (sym_cnt == 2'd2) && (sc_cnt >= 8'd56) && (sc_cnt <= 8'd182);
        sel_dmrs  = s_axis_in_tvalid && pbch_band && (sc_cnt[1:0] == v_eff);
        sel_pbch  = s_axis_in_tvalid && pbch_band && (sc_cnt[1:0] != v_eff);
        sel_sss   = s_axis_in_tvalid && sss_band;
        tlast_err = s_axis_in_tvalid && (s_axis_in_tlast != at_last);
        ssb_end   = s_axis_in_tvalid && at_last && s_axis_in_tlast && (sym_cnt == 2'd3);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sc_cnt             <= '0;
            sym_cnt            <= '0;
            v_reg              <= '0;
            pbch_cnt           <= '0;
            dmrs_cnt           <= '0;
            m_axis_pbch_tdata  <= '0;
            m_axis_pbch_tlast  <= 1'b0;
            m_axis_pbch_tvalid <= 1'b0;
            m_axis_dmrs_tdata  <= '0;
            m_axis_dmrs_tlast  <= 1'b0;
            m_axis_dmrs_tvalid <= 1'b0;
            m_axis_sss_tdata   <= '0;
            m_axis_sss_tlast   <= 1'b0;
            m_axis_sss_tvalid  <= 1'b0;
            ssb_done_o         <= 1'b0;
            err_o              <= 1'b0;
        end else begin
            m_axis_pbch_tvalid <= sel_pbch;
            m_axis_dmrs_tvalid <= sel_dmrs;
            m_axis_sss_tvalid  <= sel_sss;
            ssb_done_o         <= ssb_end;
            err_o              <= tlast_err;

            if (sel_pbch) begin
                m_axis_pbch_tdata <= s_axis_in_tdata;
                m_axis_pbch_tlast <= (pbch_cnt == PBCH_LAST);
            end
            if (sel_dmrs) begin
                m_axis_dmrs_tdata <= s_axis_in_tdata;
                m_axis_dmrs_tlast <= (dmrs_cnt == DMRS_LAST);
            end
            if (sel_sss) begin
                m_axis_sss_tdata <= s_axis_in_tdata;
                m_axis_sss_tlast <= (sc_cnt == 8'd182);
            end

            if (s_axis_in_tvalid) begin
                if (first_re) begin
                    v_reg <= N_id_i[1:0];
                end
                // A misaligned tlast restarts framing so the next RE is taken as sym 0, sc 0.
                if (tlast_err || ssb_end) begin
                    sc_cnt   <= '0;
                    sym_cnt  <= '0;
                    pbch_cnt <= '0;
                    dmrs_cnt <= '0;
                end else begin
                    if (at_last) begin
                        sc_cnt  <= '0;
                        sym_cnt <= sym_cnt + 2'd1;
                    end else begin
                        sc_cnt  <= sc_cnt + 8'd1;
                    end
                    if (sel_pbch) begin
                        pbch_cnt <= pbch_cnt + 9'd1;
                    end
                    if (sel_dmrs) begin
                        dmrs_cnt <= dmrs_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ssb_re_demapper.sv
// tb/tb_ssb_re_demapper.sv - directed table-driven bench for ssb_re_demapper
module tb_ssb_re_demapper;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [9:0]  n_id = '0;
    logic [15:0] in_tdata = '0;
    logic        in_tlast = 1'b0;
    logic        in_tvalid = 1'b0;
    logic [15:0] pbch_tdata, dmrs_tdata, sss_tdata;
    logic        pbch_tlast, pbch_tvalid, dmrs_tlast, dmrs_tvalid, sss_tlast, sss_tvalid;
    logic        ssb_done, err;

    always #5 clk = ~clk;

    ssb_re_demapper #(.IN_DW(16), .NID_WIDTH(10)) dut (
        .clk_i(clk), .reset_i(reset_i), .N_id_i(n_id),
        .s_axis_in_tdata(in_tdata), .s_axis_in_tlast(in_tlast), .s_axis_in_tvalid(in_tvalid),
        .m_axis_pbch_tdata(pbch_tdata), .m_axis_pbch_tlast(pbch_tlast), .m_axis_pbch_tvalid(pbch_tvalid),
        .m_axis_dmrs_tdata(dmrs_tdata), .m_axis_dmrs_tlast(dmrs_tlast), .m_axis_dmrs_tvalid(dmrs_tvalid),
        .m_axis_sss_tdata(sss_tdata), .m_axis_sss_tlast(sss_tlast), .m_axis_sss_tvalid(sss_tvalid),
        .ssb_done_o(ssb_done), .err_o(err)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference position classes: 0 PBCH, 1 DMRS, 2 SSS, 3 dropped
    function automatic int cls(input int sym, input int sc, input int v);
        if (sym == 0) return 3;
        if (sym == 2 && sc >= 56 && sc <= 182) return 2;
        if (sym == 2 && sc > 47 && sc < 192) return 3;
        return (sc % 4 == v) ? 1 : 0;
    endfunction

    int cnt[3], first_d[3], last_d[3], sum_d[3], tl_cnt[3], tl_last[3], misc[3];
    int done_cnt, err_cnt, done_bad, dmrs_mid;
    int cur_v = 0;
    bit mon_clr = 0;

    task automatic rec(input int k, input int d, input bit tl);
        if (cnt[k] == 0) first_d[k] = d;
        cnt[k]++;
        last_d[k] = d;
        sum_d[k] += d;
        tl_last[k] = tl;
        if (tl) tl_cnt[k]++;
        if (cls(d >> 8, d & 255, cur_v) != k) misc[k]++;
    endtask

    always @(negedge clk) begin
        if (mon_clr) begin
            for (int k = 0; k < 3; k++) begin
                cnt[k] = 0; first_d[k] = 0; last_d[k] = 0; sum_d[k] = 0;
                tl_cnt[k] = 0; tl_last[k] = 0; misc[k] = 0;
            end
            done_cnt = 0; err_cnt = 0; done_bad = 0; dmrs_mid = 0;
        end else if (!reset_i) begin
            if (pbch_tvalid) rec(0, int'(pbch_tdata), pbch_tlast);
            if (dmrs_tvalid) begin
                rec(1, int'(dmrs_tdata), dmrs_tlast);
                if (dmrs_tdata >= 16'h230 && dmrs_tdata <= 16'h2BF) dmrs_mid++;
            end
            if (sss_tvalid) rec(2, int'(sss_tdata), sss_tlast);
            if (err) err_cnt++;
            if (ssb_done) begin
                done_cnt++;
                if (!((pbch_tvalid && pbch_tlast) || (dmrs_tvalid && dmrs_tlast))) done_bad++;
            end
        end
    end

    task automatic mon_clear();
        mon_clr = 1;
        @(posedge clk);
        @(posedge clk);
        mon_clr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_tvalid = 1'b0;
            in_tlast  = 1'b0;
        end
    endtask

    task automatic send_re(input int d, input bit tl, input int nid);
        @(negedge clk);
        n_id      = 10'(nid);
        in_tdata  = 16'(d);
        in_tlast  = tl;
        in_tvalid = 1'b1;
    endtask

    // chg_at: flat RE index (sym*240+sc) from which N_id switches to nid_new; -1 for never
    task automatic send_ssb(input int nid, input int idle_pct, input int chg_at, input int nid_new);
        for (int sym = 0; sym < 4; sym++) begin
            for (int sc = 0; sc < 240; sc++) begin
                if (idle_pct > 0)
                    while ($urandom_range(99) < idle_pct) idle(1);
                send_re(sym * 256 + sc, sc == 239,
                        (chg_at >= 0 && sym * 240 + sc >= chg_at) ? nid_new : nid);
            end
        end
        idle(3);
    endtask

    task automatic check_clean(input string tag, input int dfirst, input int dlast, input int plast);
        chk({tag, " pbch_cnt"}, cnt[0], 432);
        chk({tag, " dmrs_cnt"}, cnt[1], 144);
        chk({tag, " sss_cnt"}, cnt[2], 127);
        chk({tag, " dmrs_first"}, first_d[1], dfirst);
        chk({tag, " dmrs_last"}, last_d[1], dlast);
        chk({tag, " pbch_last"}, last_d[0], plast);
        chk({tag, " sss_first"}, first_d[2], 'h238);
        chk({tag, " sss_last"}, last_d[2], 'h2B6);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s tlast_cnt[%0d]", tag, k), tl_cnt[k], 1);
            chk($sformatf("%s tlast_on_last[%0d]", tag, k), tl_last[k], 1);
            chk($sformatf("%s misclass[%0d]", tag, k), misc[k], 0);
        end
        chk({tag, " dmrs_sym2_mid"}, dmrs_mid, 0);
        chk({tag, " done_cnt"}, done_cnt, 1);
        chk({tag, " done_with_last"}, done_bad, 0);
        chk({tag, " err_cnt"}, err_cnt, 0);
    endtask

    typedef struct {
        int nid;
        int dmrs_first;
        int dmrs_last;
        int pbch_last;
    } vec_t;

    vec_t vecs[4];
    int   exp_sum[3];

    initial begin
        vecs[0] = '{nid: 0,    dmrs_first: 'h100, dmrs_last: 'h3EC, pbch_last: 'h3EF};
        vecs[1] = '{nid: 1003, dmrs_first: 'h103, dmrs_last: 'h3EF, pbch_last: 'h3EE};
        vecs[2] = '{nid: 1,    dmrs_first: 'h101, dmrs_last: 'h3ED, pbch_last: 'h3EF};
        vecs[3] = '{nid: 2,    dmrs_first: 'h102, dmrs_last: 'h3EE, pbch_last: 'h3EF};

        #12;
        chk("reset pbch_tvalid", int'(pbch_tvalid), 0);
        chk("reset dmrs_tvalid", int'(dmrs_tvalid), 0);
        chk("reset sss_tvalid", int'(sss_tvalid), 0);
        chk("reset tdata_or", int'(pbch_tdata | dmrs_tdata | sss_tdata), 0);
        chk("reset done_err", int'({ssb_done, err}), 0);
        @(negedge clk);
        reset_i = 1'b0;
        idle(2);

        foreach (vecs[i]) begin
            mon_clear();
            cur_v = vecs[i].nid % 4;
            send_ssb(vecs[i].nid, 0, -1, 0);
            check_clean($sformatf("vec%0d", i), vecs[i].dmrs_first, vecs[i].dmrs_last, vecs[i].pbch_last);
        end

        // N_id changes mid-SSB: offset stays 0 until the next SSB
        mon_clear();
        cur_v = 0;
        send_ssb(0, 0, 250, 2);
        check_clean("nid_chg", 'h100, 'h3EC, 'h3EF);
        mon_clear();
        cur_v = 2;
        send_ssb(2, 0, -1, 0);
        check_clean("nid_next", 'h102, 'h3EE, 'h3EF);

        // Three back-to-back SSBs with random idle cycles
        exp_sum = '{0, 0, 0};
        for (int sym = 0; sym < 4; sym++)
            for (int sc = 0; sc < 240; sc++)
                if (cls(sym, sc, 0) < 3) exp_sum[cls(sym, sc, 0)] += 3 * (sym * 256 + sc);
        mon_clear();
        cur_v = 0;
        for (int s = 0; s < 3; s++) send_ssb(0, 30, -1, 0);
        chk("gap pbch_cnt", cnt[0], 3 * 432);
        chk("gap dmrs_cnt", cnt[1], 3 * 144);
        chk("gap sss_cnt", cnt[2], 3 * 127);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("gap sum[%0d]", k), sum_d[k], exp_sum[k]);
            chk($sformatf("gap tlast_cnt[%0d]", k), tl_cnt[k], 3);
            chk($sformatf("gap misclass[%0d]", k), misc[k], 0);
        end
        chk("gap done_cnt", done_cnt, 3);
        chk("gap done_with_last", done_bad, 0);
        chk("gap err_cnt", err_cnt, 0);

        // Early tlast at sym 1 sc 100
        mon_clear();
        for (int sc = 0; sc < 240; sc++) send_re(sc, sc == 239, 0);
        for (int sc = 0; sc < 100; sc++) send_re(256 + sc, 1'b0, 0);
        send_re('h164, 1'b1, 0);
        @(posedge clk);
        #1;
        chk("abort err_pulse", int'(err), 1);
        chk("abort re_output", int'(dmrs_tvalid), 1);
        chk("abort re_data", int'(dmrs_tdata), 'h164);
        idle(1);
        @(posedge clk);
        #1;
        chk("abort err_one_cycle", int'(err), 0);
        idle(3);
        chk("abort done_cnt", done_cnt, 0);
        chk("abort err_cnt", err_cnt, 1);
        mon_clear();
        send_ssb(0, 0, -1, 0);
        check_clean("post_abort", 'h100, 'h3EC, 'h3EF);

        // Asynchronous reset at sym 2 sc 120
        for (int sym = 0; sym < 2; sym++)
            for (int sc = 0; sc < 240; sc++) send_re(sym * 256 + sc, sc == 239, 0);
        for (int sc = 0; sc <= 120; sc++) send_re(512 + sc, 1'b0, 0);
        @(posedge clk);
        #2;
        reset_i = 1'b1;
        #1;
        chk("async_rst tvalid_or", int'(pbch_tvalid | dmrs_tvalid | sss_tvalid), 0);
        chk("async_rst pbch_tdata", int'(pbch_tdata), 0);
        chk("async_rst sss_tdata", int'(sss_tdata), 0);
        chk("async_rst flags", int'({pbch_tlast, dmrs_tlast, sss_tlast, ssb_done, err}), 0);
        idle(2);
        reset_i = 1'b0;
        idle(1);
        mon_clear();
        send_ssb(0, 0, -1, 0);
        check_clean("post_rst", 'h100, 'h3EC, 'h3EF);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
